exe_stage: RTL and testbench

Execute stage of the five-stage in-order pipeline, between the decode stage and the memory stage. It latches one instruction from decode and computes the ALU result. Divide/modulo instructions run on a multi-cycle iterative divider. The stage issues the data-SRAM request for loads and stores, then hands `{res_from_mem, rf_we, rf_waddr, result}` to the memory stage through a valid/allowin handshake.

---
 rtl/exe_stage_pkg.sv | 47 ++++
 rtl/exe_divider.sv | 96 +++++++++
 rtl/exe_stage.sv | 135 +++++++++++++
 tb/tb_exe_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, decode-bus field
// offsets, ALU/divide opcode bit positions, divider state encoding and an
// absolute-value helper used by the divider.
package exe_stage_pkg;

   localparam int DS_ES_BUS_W = 120;
   localparam int ES_MS_BUS_W = 39;

   // decode payload field offsets
   localparam int BUS_ALU_OP_LSB   = 108;
   localparam int BUS_DIV_OP_LSB   = 104;
   localparam int BUS_RES_FROM_MEM = 103;
   localparam int BUS_MEM_WE       = 102;
   localparam int BUS_RF_WE        = 101;
   localparam int BUS_RF_WADDR_LSB = 96;
   localparam int BUS_RKD_LSB      = 64;
   localparam int BUS_SRC1_LSB     = 32;
   localparam int BUS_SRC2_LSB     = 0;

   // alu_op one-hot bit positions
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   // div_op one-hot bit positions
   localparam int DIV_W  = 0;
   localparam int MOD_W  = 1;
   localparam int DIV_WU = 2;
   localparam int MOD_WU = 3;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   // Magnitude of v when it is to be read as signed; pass-through otherwise.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/exe_divider.sv
// Radix-2 restoring divider, 32 iterations. Signed operations divide the
// magnitudes and fix the signs at the output: quotient negated when operand
// signs differ, remainder follows the dividend. Divide by zero returns an
// all-ones quotient and the dividend as remainder. The result is held in
// DONE until ack.
module exe_divider
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   input  logic        ack,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   div_state_t  state, state_nxt;
   logic [4:0]  count;
   logic [31:0] rem_q;     // partial remainder
   logic [31:0] quo_q;     // dividend bits shift out the top, quotient bits in the bottom
   logic [31:0] dsr_q;     // divisor magnitude
   logic [31:0] dvd_q;     // original dividend, returned on divide by zero
   logic        neg_q, neg_r, dz;
   logic [32:0] trial, diff;
   logic        q_bit;
   logic [31:0] rem_nxt;

   // one restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      trial   = {rem_q, quo_q[31]};
      diff    = trial - {1'b0, dsr_q};
      q_bit   = ~diff[32];
      rem_nxt = q_bit ? diff[31:0] : trial[31:0];
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (count == 5'd31) state_nxt = DONE;
         DONE:    if (ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register, operand capture and iteration datapath
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         count <= 5'd0;
         rem_q <= 32'd0;
         quo_q <= 32'd0;
         dsr_q <= 32'd0;
         dvd_q <= 32'd0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            rem_q <= 32'd0;
            quo_q <= abs32(dividend, signed_op);
            dsr_q <= abs32(divisor, signed_op);
            dvd_q <= dividend;
            neg_q <= signed_op & (dividend[31] ^ divisor[31]);
            neg_r <= signed_op & dividend[31];
            dz    <= (divisor == 32'd0);
            count <= 5'd0;
         end else if (state == BUSY) begin
            rem_q <= rem_nxt;
            quo_q <= {quo_q[30:0], q_bit};
            count <= count + 5'd1;
         end
      end
   end

   // sign correction and divide-by-zero override
   always_comb begin
      quotient  = neg_q ? (~quo_q + 32'd1) : quo_q;
      remainder = neg_r ? (~rem_q + 32'd1) : rem_q;
      if (dz) begin
         quotient  = 32'hFFFF_FFFF;
         remainder = dvd_q;
      end
   end

   assign busy = (state == BUSY);
   assign done = (state == DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches one instruction from decode, computes the ALU
// result (or divider result for div/mod), issues the data-SRAM request on
// the transfer cycle and forwards {res_from_mem, rf_we, rf_waddr, result}.
// Handshake: an instruction moves from EXE to MEM on a cycle where
// es2ms_valid and ms_allowin are both high; EXE accepts from decode when
// ds2es_valid and es_allowin are both high.
// Build option: define EXE_DIV_EN to include the iterative divider; without
// it div_op is ignored and every instruction completes in one cycle.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   output logic                   es_allowin,
   input  logic                   ds2es_valid,
   input  logic [DS_ES_BUS_W-1:0] ds_es_bus,
   input  logic [31:0]            ds_pc,
   input  logic                   ms_allowin,
   output logic [ES_MS_BUS_W-1:0] es_rf_zip,
   output logic                   es2ms_valid,
   output logic [31:0]            es_pc,
   output logic                   data_sram_en,
   output logic [3:0]             data_sram_we,
   output logic [31:0]            data_sram_addr,
   output logic [31:0]            data_sram_wdata
);

   logic        es_valid, es_ready_go, handoff;
   logic [11:0] alu_op;
   logic [3:0]  div_op;
   logic        res_from_mem, mem_we, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rkd_value, src1, src2;
   logic [31:0] alu_result, es_result;

   assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
   assign es2ms_valid = es_valid & es_ready_go;
   assign handoff     = es2ms_valid & ms_allowin;

   // valid bit: updated whenever the stage can accept, otherwise held
   always_ff @(posedge clk) begin
      if (!resetn)         es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds2es_valid;
   end

   // payload latch on an accepted instruction
   always_ff @(posedge clk) begin
      if (!resetn) begin
         alu_op       <= 12'd0;
         div_op       <= 4'd0;
         res_from_mem <= 1'b0;
         mem_we       <= 1'b0;
         rf_we        <= 1'b0;
         rf_waddr     <= 5'd0;
         rkd_value    <= 32'd0;
         src1         <= 32'd0;
         src2         <= 32'd0;
         es_pc        <= 32'd0;
      end else if (ds2es_valid && es_allowin) begin
         alu_op       <= ds_es_bus[BUS_ALU_OP_LSB +: 12];
         div_op       <= ds_es_bus[BUS_DIV_OP_LSB +: 4];
         res_from_mem <= ds_es_bus[BUS_RES_FROM_MEM];
         mem_we       <= ds_es_bus[BUS_MEM_WE];
         rf_we        <= ds_es_bus[BUS_RF_WE];
         rf_waddr     <= ds_es_bus[BUS_RF_WADDR_LSB +: 5];
         rkd_value    <= ds_es_bus[BUS_RKD_LSB +: 32];
         src1         <= ds_es_bus[BUS_SRC1_LSB +: 32];
         src2         <= ds_es_bus[BUS_SRC2_LSB +: 32];
         es_pc        <= ds_pc;
      end
   end

   // one-hot ALU, 32-bit wrapping arithmetic
   always_comb begin
      alu_result = 32'd0;
      if (alu_op[ALU_ADD])       alu_result = src1 + src2;
      else if (alu_op[ALU_SUB])  alu_result = src1 - src2;
      else if (alu_op[ALU_SLT])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      else if (alu_op[ALU_SLTU]) alu_result = {31'd0, src1 < src2};
      else if (alu_op[ALU_AND])  alu_result = src1 & src2;
      else if (alu_op[ALU_NOR])  alu_result = ~(src1 | src2);
      else if (alu_op[ALU_OR])   alu_result = src1 | src2;
      else if (alu_op[ALU_XOR])  alu_result = src1 ^ src2;
      else if (alu_op[ALU_SLL])  alu_result = src1 << src2[4:0];
      else if (alu_op[ALU_SRL])  alu_result = src1 >> src2[4:0];
      else if (alu_op[ALU_SRA])  alu_result = $unsigned($signed(src1) >>> src2[4:0]);
      else if (alu_op[ALU_LUI])  alu_result = src2;
   end

`ifdef EXE_DIV_EN
   logic        div_start, div_fin, div_busy_unused, div_done;
   logic [31:0] div_q, div_r;

   // start only once per instruction; the flag drops when it leaves EXE
   assign div_start = es_valid & (|div_op) & ~div_done;

   // div_done: this instruction has already been handed to the divider
   always_ff @(posedge clk) begin
      if (!resetn)        div_done <= 1'b0;
      else if (handoff)   div_done <= 1'b0;
      else if (div_start) div_done <= 1'b1;
   end

   // busy is not needed here: done alone gates the hand-off
   exe_divider u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (div_start),
      .signed_op (div_op[DIV_W] | div_op[MOD_W]),
      .dividend  (src1),
      .divisor   (src2),
      .busy      (div_busy_unused),
      .done      (div_fin),
      .ack       (handoff),
      .quotient  (div_q),
      .remainder (div_r)
   );

   assign es_ready_go = ~(|div_op) | div_fin;
   assign es_result   = (|div_op) ? ((div_op[DIV_W] | div_op[DIV_WU]) ? div_q : div_r)
                                  : alu_result;
`else
   logic div_unused;
   assign div_unused  = ^div_op;
   assign es_ready_go = 1'b1;
   assign es_result   = alu_result;
`endif

   assign es_rf_zip       = {res_from_mem, rf_we & es_valid, rf_waddr, es_result};
   assign data_sram_en    = handoff & (res_from_mem | mem_we);
   assign data_sram_we    = {4{mem_we & handoff}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage. Works in both builds: with EXE_DIV_EN the model
// expects divider results after 33 cycles, otherwise ALU results at once.
module tb_exe_stage;

   logic         clk = 1'b0;
   logic         resetn;
   logic         es_allowin;
   logic         ds2es_valid;
   logic [119:0] ds_es_bus;
   logic [31:0]  ds_pc;
   logic         ms_allowin;
   logic [38:0]  es_rf_zip;
   logic         es2ms_valid;
   logic [31:0]  es_pc;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int checks = 0;
   int errors = 0;
   logic [38:0] exp_q[$];

`ifdef EXE_DIV_EN
   localparam bit DIV_ON  = 1'b1;
   localparam int DIV_LAT = 33;
`else
   localparam bit DIV_ON  = 1'b0;
   localparam int DIV_LAT = 0;
`endif

   exe_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .es_allowin      (es_allowin),
      .ds2es_valid     (ds2es_valid),
      .ds_es_bus       (ds_es_bus),
      .ds_pc           (ds_pc),
      .ms_allowin      (ms_allowin),
      .es_rf_zip       (es_rf_zip),
      .es2ms_valid     (es2ms_valid),
      .es_pc           (es_pc),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   // clock and global time limit
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (idx)
         0:  return a + b;
         1:  return a - b;
         2:  return (sa < sb) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return a << b[4:0];
         9:  return a >> b[4:0];
         10: return sa >>> b[4:0];
         11: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_div(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
      logic is_signed, want_q;
      int sa, sb;
      logic [31:0] q, r;
      is_signed = dop[0] | dop[1];
      want_q    = dop[0] | dop[2];
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (is_signed) begin
         sa = a;
         sb = b;
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return want_q ? q : r;
   endfunction

   function automatic int onehot_idx(input logic [11:0] aop);
      int idx;
      idx = -1;
      for (int i = 0; i < 12; i++) if (aop[i] && idx < 0) idx = i;
      return idx;
   endfunction

   function automatic logic [31:0] exp_result(input logic [11:0] aop, input logic [3:0] dop,
                                              input logic [31:0] a, input logic [31:0] b);
      if (DIV_ON && dop != 4'd0) return ref_div(dop, a, b);
      return ref_alu(onehot_idx(aop), a, b);
   endfunction

   // ---------------- driver: one instruction through EXE ----------------
   task automatic run_one(input logic [11:0] aop, input logic [3:0] dop, input logic rfm,
                          input logic mwe, input logic rfwe, input logic [4:0] wa,
                          input logic [31:0] rkd, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] pc, input int stall);
      logic [38:0] exp_zip;
      logic [31:0] exp_addr;
      int lat, exp_lat, n;
      bit allow_bad;
      exp_q.push_back({rfm, rfwe, wa, exp_result(aop, dop, s1, s2)});
      exp_addr   = ref_alu(onehot_idx(aop), s1, s2);
      exp_lat    = (DIV_ON && dop != 4'd0) ? DIV_LAT : 0;
      ms_allowin = (stall == 0);
      ds_es_bus  = {aop, dop, rfm, mwe, rfwe, wa, rkd, s1, s2};
      ds_pc      = pc;
      ds2es_valid = 1'b1;
      n = 0;
      while (!es_allowin && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (es_allowin !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: es_allowin=%b after %0d cycles, required 1", es_allowin, n);
      end
      @(posedge clk); #1;
      ds2es_valid = 1'b0;
      ds_es_bus   = {$urandom, $urandom, $urandom, $urandom};
      ds_pc       = $urandom;
      lat = 0;
      allow_bad = 1'b0;
      while (!es2ms_valid && lat < 100) begin
         if (es_allowin) allow_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required %0d", lat, exp_lat);
      end
      checks++;
      if (allow_bad) begin
         errors++;
         $display("FAIL allowin_busy: es_allowin=1 while result pending, required 0");
      end
      checks++;
      if (es_pc !== pc) begin
         errors++;
         $display("FAIL es_pc: got %h, required %h", es_pc, pc);
      end
      for (int i = 0; i < stall; i++) begin
         checks++;
         if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0 || es_rf_zip !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_hold: en=%b we=%h zip=%h, required en=0 we=0 zip=%h",
                     data_sram_en, data_sram_we, es_rf_zip, exp_q[0]);
         end
         @(posedge clk); #1;
      end
      ms_allowin = 1'b1;
      #1;
      exp_zip = exp_q.pop_front();
      checks++;
      if (es_rf_zip !== exp_zip) begin
         errors++;
         $display("FAIL zip: got %h, required %h", es_rf_zip, exp_zip);
      end
      checks++;
      if (data_sram_en !== (rfm | mwe) || data_sram_we !== {4{mwe}}) begin
         errors++;
         $display("FAIL sram_req: en=%b we=%h, required en=%b we=%h",
                  data_sram_en, data_sram_we, rfm | mwe, {4{mwe}});
      end
      checks++;
      if (data_sram_addr !== exp_addr || data_sram_wdata !== rkd) begin
         errors++;
         $display("FAIL sram_addr_data: addr=%h wdata=%h, required addr=%h wdata=%h",
                  data_sram_addr, data_sram_wdata, exp_addr, rkd);
      end
      @(posedge clk); #1;
      checks++;
      if (data_sram_en !== 1'b0 || es2ms_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_handoff: en=%b es2ms_valid=%b, required 0 0", data_sram_en, es2ms_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn      = 1'b0;
      ds2es_valid = 1'b1;
      ds_es_bus   = {$urandom, $urandom, $urandom, $urandom};
      ds_pc       = $urandom;
      ms_allowin  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (es2ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
         errors++;
         $display("FAIL reset_hs: es2ms_valid=%b es_allowin=%b, required 0 1", es2ms_valid, es_allowin);
      end
      checks++;
      if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0) begin
         errors++;
         $display("FAIL reset_sram: en=%b we=%h, required 0 0", data_sram_en, data_sram_we);
      end
      checks++;
      if (es_pc !== 32'd0 || es_rf_zip !== 39'd0) begin
         errors++;
         $display("FAIL reset_payload: pc=%h zip=%h, required 0 0", es_pc, es_rf_zip);
      end
      ds2es_valid = 1'b0;
      resetn      = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      logic [11:0] aop;
      // overflow wrap from the directed plan
      run_one(12'h001, 4'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'h1C00_0000, 0);
      for (int k = 0; k < 40; k++) begin
         aop = 12'd1 << $urandom_range(0, 11);
         run_one(aop, 4'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 $urandom, $urandom_range(0, 2));
      end
   endtask

   task automatic test_div();
      logic [31:0] a, b;
      logic [3:0]  dop;
      run_one(12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'h100, 0);
      run_one(12'h001, 4'b0010, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'h104, 0);
      run_one(12'h001, 4'b0100, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0, 32'h1234_5678, 32'd0, 32'h108, 0);
      run_one(12'h001, 4'b1000, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1234_5678, 32'd0, 32'h10C, 1);
      run_one(12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h110, 0);
      run_one(12'h001, 4'b0010, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h114, 2);
      run_one(12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd10, 32'd0, 32'h8765_4321, 32'd0, 32'h118, 0);
      for (int k = 0; k < 24; k++) begin
         dop = 4'd1 << $urandom_range(0, 3);
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_one(12'h001, dop, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 a, b, $urandom, $urandom_range(0, 2));
      end
   endtask

   task automatic test_store_stall();
      run_one(12'h001, 4'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h10, 32'hC, 32'h200, 3);
      run_one(12'h001, 4'h0, 1'b1, 1'b0, 1'b1, 5'd12, 32'd0, 32'h40, 32'h4, 32'h204, 2);
   endtask

   task automatic test_reset_mid_div();
      ms_allowin  = 1'b1;
      ds_es_bus   = {12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd2, 32'd0, 32'h7654_3210, 32'd3};
      ds_pc       = 32'h300;
      ds2es_valid = 1'b1;
      @(posedge clk); #1;
      ds2es_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (es2ms_valid !== 1'b0 || es_allowin !== 1'b1 || es_rf_zip !== 39'd0) begin
         errors++;
         $display("FAIL reset_mid_div: es2ms_valid=%b es_allowin=%b zip=%h, required 0 1 0",
                  es2ms_valid, es_allowin, es_rf_zip);
      end
      resetn = 1'b1;
      run_one(12'h001, 4'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'h304, 0);
      run_one(12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'h308, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      logic [38:0] exp_zip;
      int lat;
      a1 = $urandom; b1 = 32'($urandom_range(1, 1000));
      a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
      exp_q.push_back({1'b0, 1'b1, 5'd20, exp_result(12'h001, 4'b0001, a1, b1)});
      exp_q.push_back({1'b0, 1'b1, 5'd21, exp_result(12'h001, 4'b1000, a2, b2)});
      ms_allowin  = 1'b1;
      ds_es_bus   = {12'h001, 4'b0001, 1'b0, 1'b0, 1'b1, 5'd20, 32'd0, a1, b1};
      ds_pc       = 32'h400;
      ds2es_valid = 1'b1;
      @(posedge clk); #1;
      ds_es_bus   = {12'h001, 4'b1000, 1'b0, 1'b0, 1'b1, 5'd21, 32'd0, a2, b2};
      ds_pc       = 32'h404;
      for (int j = 0; j < 2; j++) begin
         lat = 0;
         while (!es2ms_valid && lat < 100) begin @(posedge clk); #1; lat++; end
         exp_zip = exp_q.pop_front();
         checks++;
         if (lat != DIV_LAT || es_rf_zip !== exp_zip) begin
            errors++;
            $display("FAIL b2b_%0d: lat=%0d zip=%h, required lat=%0d zip=%h",
                     j, lat, es_rf_zip, DIV_LAT, exp_zip);
         end
         checks++;
         if (es_allowin !== 1'b1) begin
            errors++;
            $display("FAIL b2b_allowin_%0d: es_allowin=%b at hand-off, required 1", j, es_allowin);
         end
         @(posedge clk); #1;
         ds2es_valid = 1'b0;
         if (j == 0) begin
            checks++;
            if (es_pc !== 32'h404) begin
               errors++;
               $display("FAIL b2b_pc: got %h, required 00000404", es_pc);
            end
         end
      end
      checks++;
      if (es2ms_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: es2ms_valid=%b, required 0", es2ms_valid);
      end
   endtask

   initial begin
      resetn      = 1'b0;
      ds2es_valid = 1'b0;
      ds_es_bus   = '0;
      ds_pc       = '0;
      ms_allowin  = 1'b1;
      test_reset();
      test_alu();
      test_div();
      test_store_stall();
      test_reset_mid_div();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
